// File: rtl/ula_issue.sv
// Issue/control stage for the combinational ALU: decodes a request,
// drives the ALU from registers, waits a settle window, returns result.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake
//   alu_op, funct          operation class and MIPS R-type funct
//   op_a, op_b             request operands
//   alu_a, alu_b, alu_sel  registered ALU drive
//   alu_s                  combinational ALU result
//   out_valid/out_ready    response handshake
//   result, zero, illegal  captured response
//
// alu_sel encoding: 0=ADD 1=SUB 2=AND 3=OR 4=NOR 5=SLT 6=SLTU
module ula_issue #(
    parameter int SETTLE_CYCLES = 1,
    parameter int WIDTH         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLTU = 3'd6;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;

    logic [2:0]       dec_op;
    logic             dec_ill;

    // Illegal requests still get a defined select (ADD).
    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        unique case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                unique case (funct)
                    6'h20, 6'h21: dec_op = OP_ADD;
                    6'h22, 6'h23: dec_op = OP_SUB;
                    6'h24:        dec_op = OP_AND;
                    6'h25:        dec_op = OP_OR;
                    6'h27:        dec_op = OP_NOR;
                    6'h2A:        dec_op = OP_SLT;
                    6'h2B:        dec_op = OP_SLTU;
                    default:      dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    sel_d = dec_op;
                    if (dec_ill) begin
                        res_d   = '0;
                        zero_d  = 1'b0;
                        ill_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = alu_s;
                    zero_d  = (alu_s == '0);
                    ill_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= OP_ADD;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_ula_issue.sv
// Bench for ula_issue: table vectors, random requests vs reference model,
// backpressure and mid-operation reset on SETTLE_CYCLES=1 and =4 copies.
module tb_ula_issue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [2];
    logic        ir   [2];
    logic [1:0]  aop  [2];
    logic [5:0]  fn   [2];
    logic [31:0] opa  [2];
    logic [31:0] opb  [2];
    logic [31:0] aa   [2];
    logic [31:0] ab   [2];
    logic [2:0]  asel [2];
    logic [31:0] as_  [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [31:0] res  [2];
    logic        zr   [2];
    logic        il   [2];

    int errors = 0;
    int checks = 0;
    int lat_of [2];

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [2:0] s);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return {31'd0, $signed(a) < $signed(b)};
            3'd6: return {31'd0, a < b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign as_[0] = alu_f(aa[0], ab[0], asel[0]);
    assign as_[1] = alu_f(aa[1], ab[1], asel[1]);

    ula_issue #(.SETTLE_CYCLES(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .alu_op(aop[0]), .funct(fn[0]), .op_a(opa[0]), .op_b(opb[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_sel(asel[0]), .alu_s(as_[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .result(res[0]), .zero(zr[0]), .illegal(il[0])
    );

    ula_issue #(.SETTLE_CYCLES(4), .WIDTH(32)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .alu_op(aop[1]), .funct(fn[1]), .op_a(opa[1]), .op_b(opb[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_sel(asel[1]), .alu_s(as_[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .result(res[1]), .zero(zr[1]), .illegal(il[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: spec-level decode and arithmetic straight from alu_op/funct.
    task automatic ref_model(input logic [1:0] op, input logic [5:0] f,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic z,
                             output logic ill);
        ill = 1'b0;
        r   = 32'd0;
        if (op == 2'b00) r = a + b;
        else if (op == 2'b01) r = a - b;
        else if (op == 2'b10) begin
            if (f == 6'h20 || f == 6'h21) r = a + b;
            else if (f == 6'h22 || f == 6'h23) r = a - b;
            else if (f == 6'h24) r = a & b;
            else if (f == 6'h25) r = a | b;
            else if (f == 6'h27) r = ~(a | b);
            else if (f == 6'h2A) r = ($signed(a) < $signed(b)) ? 1 : 0;
            else if (f == 6'h2B) r = (a < b) ? 1 : 0;
            else ill = 1'b1;
        end else ill = 1'b1;
        if (ill) r = 32'd0;
        z = !ill && (r == 32'd0);
    endtask

    // Called at a negedge; returns at a negedge after the response handshake.
    task automatic run_req(input int d, input logic [1:0] op,
                           input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int hold,
                           input logic [31:0] er, input logic ez,
                           input logic ei, input bit csel,
                           input logic [2:0] esel);
        int n;
        int exp_lat;
        exp_lat = ei ? 1 : lat_of[d] + 1;
        chk("in_ready idle", {31'd0, ir[d]}, 32'd1);
        iv[d] = 1'b1; aop[d] = op; fn[d] = f; opa[d] = a; opb[d] = b;
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        aop[d] = 2'($urandom); opa[d] = $urandom; opb[d] = $urandom;
        n = 1;
        chk("alu_a latch", aa[d], a);
        chk("alu_b latch", ab[d], b);
        if (csel) chk("alu_sel", {29'd0, asel[d]}, {29'd0, esel});
        while (!ov[d] && n < 40) begin
            chk("in_ready busy", {31'd0, ir[d]}, 32'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        for (int k = 0; k <= hold; k++) begin
            chk("out_valid held", {31'd0, ov[d]}, 32'd1);
            chk("in_ready resp", {31'd0, ir[d]}, 32'd0);
            chk("result", res[d], er);
            chk("zero", {31'd0, zr[d]}, {31'd0, ez});
            chk("illegal", {31'd0, il[d]}, {31'd0, ei});
            if (k == hold) ordy[d] = 1'b1;
            @(negedge clk);
        end
        ordy[d] = 1'b0;
        chk("out_valid drop", {31'd0, ov[d]}, 32'd0);
        chk("in_ready back", {31'd0, ir[d]}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] er;
        logic        ez;
        logic        ei;
        logic [2:0]  esel;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0] r;
        logic        z, ill;
        logic [5:0]  fl [9];
        lat_of[0] = 1;
        lat_of[1] = 4;
        fl[0] = 6'h20; fl[1] = 6'h21; fl[2] = 6'h22; fl[3] = 6'h23;
        fl[4] = 6'h24; fl[5] = 6'h25; fl[6] = 6'h27; fl[7] = 6'h2A;
        fl[8] = 6'h2B;

        vt[0]  = '{2'b00, 6'h00, 32'd5, 32'd7, 0, 32'd12, 1'b0, 1'b0, 3'd0};
        vt[1]  = '{2'b01, 6'h00, 32'h1234, 32'h1234, 5, 32'd0, 1'b1, 1'b0, 3'd1};
        vt[2]  = '{2'b10, 6'h24, 32'hF0, 32'h0F, 0, 32'd0, 1'b1, 1'b0, 3'd2};
        vt[3]  = '{2'b10, 6'h25, 32'hF0, 32'h0F, 1, 32'hFF, 1'b0, 1'b0, 3'd3};
        vt[4]  = '{2'b10, 6'h27, 32'hF0, 32'h0F, 0, 32'hFFFFFF00, 1'b0, 1'b0, 3'd4};
        vt[5]  = '{2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 1'b0, 1'b0, 3'd5};
        vt[6]  = '{2'b10, 6'h2B, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b1, 1'b0, 3'd6};
        vt[7]  = '{2'b10, 6'h00, 32'd9, 32'd3, 2, 32'd0, 1'b0, 1'b1, 3'd0};
        vt[8]  = '{2'b11, 6'h20, 32'd9, 32'd3, 0, 32'd0, 1'b0, 1'b1, 3'd0};
        vt[9]  = '{2'b10, 6'h21, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b1, 1'b0, 3'd0};
        vt[10] = '{2'b10, 6'h23, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 1'b0, 1'b0, 3'd1};
        vt[11] = '{2'b10, 6'h20, 32'd100, 32'd28, 0, 32'd128, 1'b0, 1'b0, 3'd0};
        vt[12] = '{2'b10, 6'h22, 32'd1, 32'd2, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 3'd1};

        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; aop[d] = 2'b00; fn[d] = 6'h00;
            opa[d] = 32'd0; opb[d] = 32'd0; ordy[d] = 1'b0;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst in_ready", {31'd0, ir[d]}, 32'd1);
            chk("rst out_valid", {31'd0, ov[d]}, 32'd0);
            chk("rst result", res[d], 32'd0);
            chk("rst zero", {31'd0, zr[d]}, 32'd0);
            chk("rst illegal", {31'd0, il[d]}, 32'd0);
            chk("rst alu_sel", {29'd0, asel[d]}, 32'd0);
            chk("rst alu_a", aa[d], 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 13; i++)
                run_req(d, vt[i].op, vt[i].f, vt[i].a, vt[i].b, vt[i].hold,
                        vt[i].er, vt[i].ez, vt[i].ei, 1'b1, vt[i].esel);

        // in_valid outside IDLE is ignored: pulse it mid-EXEC on dut4.
        iv[1] = 1'b1; aop[1] = 2'b00; opa[1] = 32'd1; opb[1] = 32'd2;
        @(posedge clk);
        @(negedge clk);
        aop[1] = 2'b01; opa[1] = 32'd50; opb[1] = 32'd60;
        @(negedge clk);
        iv[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("ignore ov", {31'd0, ov[1]}, 32'd1);
        chk("ignore result", res[1], 32'd3);
        chk("ignore alu_a", aa[1], 32'd1);
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        chk("ignore back idle", {31'd0, ir[1]}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [5:0]  f;
            logic [31:0] a, b;
            int          d;
            d  = i % 2;
            op = 2'($urandom);
            f  = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                             : fl[$urandom_range(0, 8)];
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
            ref_model(op, f, a, b, r, z, ill);
            run_req(d, op, f, a, b, $urandom_range(0, 2), r, z, ill,
                    1'b0, 3'd0);
        end

        // Reset in the 2nd EXEC cycle of dut4 drops the request.
        iv[1] = 1'b1; aop[1] = 2'b00; opa[1] = 32'd11; opb[1] = 32'd22;
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0;
        chk("mid exec1", {31'd0, ir[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst in_ready", {31'd0, ir[1]}, 32'd1);
        chk("mid rst out_valid", {31'd0, ov[1]}, 32'd0);
        chk("mid rst result", res[1], 32'd0);
        begin
            int seen;
            seen = 0;
            ordy[1] = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (ov[1]) seen++;
            end
            ordy[1] = 1'b0;
            chk("mid rst no resp", seen, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
